// File: rtl/data_memory_responder_if.sv
// Request/response bundle between the memory pipeline stage and the data-memory responder.
// The master side drives requests and the slave side answers them.
interface data_memory_responder_if;
    logic        req_valid_i;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic        req_ready_o;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_fault_o;
    logic        stall_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o, stall_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o, stall_o
    );
endinterface

// File: rtl/data_memory_responder.sv
// Single-outstanding data-memory responder with WAIT_STATES wait cycles and byte-lane writes.
// Define DMEM_FAULT_EN to fault misaligned or out-of-range accesses instead of masking/wrapping them.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic                     clk_i,
    input logic                     reset_i,
    data_memory_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        resp_valid_q;
    logic        resp_fault_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        in_idle;
    logic        commit;
    logic        we;
    logic        c_write;
    logic        c_unsigned;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [1:0]  c_size;
    logic        c_fault;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd_word;
    logic [31:0] load_ext;

    assign in_idle = (state == S_IDLE);

    // With zero wait states the commit happens on the accept edge, so the
    // operands come straight from the request instead of the latched copy.
    always_comb begin
        c_write    = lat_write;
        c_unsigned = lat_unsigned;
        c_addr     = lat_addr;
        c_wdata    = lat_wdata;
        c_size     = lat_size;
        if (in_idle) begin
            c_write    = bus.req_write_i;
            c_unsigned = bus.req_unsigned_i;
            c_addr     = bus.req_addr_i;
            c_wdata    = bus.req_wdata_i;
            c_size     = bus.req_size_i;
        end
    end

`ifdef DMEM_FAULT_EN
    assign c_fault = ((c_size == 2'b01) && c_addr[0]) ||
                     (c_size[1] && (c_addr[1:0] != 2'b00)) ||
                     ({2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
    logic unused_addr_hi;
    assign c_fault        = 1'b0;
    assign unused_addr_hi = ^c_addr[31:AW+2];
`endif

    assign idx    = c_addr[AW+1:2];
    assign commit = reset_i &&
                    ((in_idle && bus.req_valid_i && ((WAIT_STATES == 0) || c_fault)) ||
                     ((state == S_WAIT) && (cnt == '0)));
    assign we     = commit && c_write && !c_fault;

    always_comb begin
        lane = 2'b00;
        be   = 4'b1111;
        wd   = c_wdata;
        case (c_size)
            2'b00: begin
                lane = c_addr[1:0];
                be   = 4'b0001 << c_addr[1:0];
                wd   = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                lane = {c_addr[1], 1'b0};
                be   = c_addr[1] ? 4'b1100 : 4'b0011;
                wd   = {2{c_wdata[15:0]}};
            end
            default: begin
                lane = 2'b00;
                be   = 4'b1111;
                wd   = c_wdata;
            end
        endcase
    end

    assign rd_word = mem[idx];

    always_comb begin
        load_ext = rd_word;
        case (c_size)
            2'b00: begin
                case (lane)
                    2'd0:    load_ext = {24'h0, rd_word[7:0]};
                    2'd1:    load_ext = {24'h0, rd_word[15:8]};
                    2'd2:    load_ext = {24'h0, rd_word[23:16]};
                    default: load_ext = {24'h0, rd_word[31:24]};
                endcase
                if (!c_unsigned && load_ext[7]) load_ext[31:8] = '1;
            end
            2'b01: begin
                load_ext = lane[1] ? {16'h0, rd_word[31:16]} : {16'h0, rd_word[15:0]};
                if (!c_unsigned && load_ext[15]) load_ext[31:16] = '1;
            end
            default: load_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state        <= S_IDLE;
            cnt          <= '0;
            lat_write    <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= '0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            if (commit) begin
                resp_valid_q <= 1'b1;
                resp_fault_q <= c_fault;
                resp_rdata_q <= (c_write || c_fault) ? '0 : load_ext;
            end
            case (state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        lat_write    <= bus.req_write_i;
                        lat_unsigned <= bus.req_unsigned_i;
                        lat_addr     <= bus.req_addr_i;
                        lat_wdata    <= bus.req_wdata_i;
                        lat_size     <= bus.req_size_i;
                        if ((WAIT_STATES == 0) || c_fault) begin
                            state <= S_RESP;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) state <= S_RESP;
                    else           cnt   <= cnt - 4'd1;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o  = reset_i && in_idle;
    assign bus.stall_o      = reset_i && ((in_idle && bus.req_valid_i) || (state == S_WAIT));
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_rdata_o = resp_rdata_q;
    assign bus.resp_fault_o = resp_fault_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder against a byte-array reference model.
// Fault-mode expectations follow DMEM_FAULT_EN when it is defined for the build.
module tb_data_memory_responder;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned WS    = 2;

    logic clk = 1'b0;
    logic reset_i = 1'b0;

    data_memory_responder_if bus();
    data_memory_responder_if bus_z();

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk_i(clk), .reset_i(reset_i), .bus(bus)
    );

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_z (
        .clk_i(clk), .reset_i(reset_i), .bus(bus_z)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [7:0] model_mem [DEPTH*4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned size_bytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_fault(input logic [31:0] addr, input logic [1:0] size);
`ifdef DMEM_FAULT_EN
        int unsigned n = size_bytes(size);
        return ((addr % n) != 0) || ((addr / 4) >= DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned eff_byte(input logic [31:0] addr, input logic [1:0] size);
        int unsigned n = size_bytes(size);
        return ((addr / n) * n) % (DEPTH * 4);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input logic uns);
        int unsigned n    = size_bytes(size);
        int unsigned base = eff_byte(addr, size);
        logic [31:0] v    = '0;
        for (int k = 0; k < int'(n); k++) v[8*k +: 8] = model_mem[base + k];
        if (!uns && n == 1 && v[7])  v[31:8]  = '1;
        if (!uns && n == 2 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        int unsigned n    = size_bytes(size);
        int unsigned base = eff_byte(addr, size);
        for (int k = 0; k < int'(n); k++) model_mem[base + k] = wdata[8*k +: 8];
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        logic        exp_fault;
        logic [31:0] exp_data;
        int unsigned exp_lat;
        int unsigned n;
        logic        got;
        exp_fault = model_fault(addr, size);
        exp_data  = (wr || exp_fault) ? 32'h0 : model_load(addr, size, uns);
        exp_lat   = exp_fault ? 1 : WS + 1;
        if (wr && !exp_fault) model_store(addr, size, wdata);

        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_write_i    = wr;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        #1;
        check_eq({tag, ".ready_idle"}, 32'(bus.req_ready_o), 32'd1);
        check_eq({tag, ".stall_req"},  32'(bus.stall_o), 32'd1);
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;

        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (bus.resp_valid_o) got = 1'b1;
            else begin
                check_eq({tag, ".stall_wait"}, 32'(bus.stall_o), 32'd1);
                check_eq({tag, ".ready_wait"}, 32'(bus.req_ready_o), 32'd0);
            end
        end
        check_eq({tag, ".latency"}, n, exp_lat);
        if (got) begin
            check_eq({tag, ".rdata"},      bus.resp_rdata_o, exp_data);
            check_eq({tag, ".fault"},      32'(bus.resp_fault_o), 32'(exp_fault));
            check_eq({tag, ".stall_resp"}, 32'(bus.stall_o), 32'd0);
            check_eq({tag, ".ready_resp"}, 32'(bus.req_ready_o), 32'd0);
            @(negedge clk);
            check_eq({tag, ".one_shot"},   32'(bus.resp_valid_o), 32'd0);
            check_eq({tag, ".ready_back"}, 32'(bus.req_ready_o), 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_addr_i = '0;
        bus.req_wdata_i = '0;   bus.req_size_i = '0;    bus.req_unsigned_i = 1'b0;
        bus_z.req_valid_i = 1'b0; bus_z.req_write_i = 1'b0; bus_z.req_addr_i = '0;
        bus_z.req_wdata_i = '0;   bus_z.req_size_i = '0;    bus_z.req_unsigned_i = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst.ready", 32'(bus.req_ready_o), 32'd0);
        check_eq("rst.valid", 32'(bus.resp_valid_o), 32'd0);
        check_eq("rst.rdata", bus.resp_rdata_o, 32'd0);
        check_eq("rst.fault", 32'(bus.resp_fault_o), 32'd0);
        check_eq("rst.stall", 32'(bus.stall_o), 32'd0);
        reset_i = 1'b1;

        for (int unsigned w = 0; w < DEPTH; w++) do_req("init", 1'b1, w * 4, $urandom, 2'b10, 1'b0);

        do_req("st_word",  1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
        do_req("ld_word",  1'b0, 32'h10, 32'h0,        2'b10, 1'b0);
        do_req("st_byte",  1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0);
        do_req("ld_bs",    1'b0, 32'h13, 32'h0,        2'b00, 1'b0);
        do_req("ld_bu",    1'b0, 32'h13, 32'h0,        2'b00, 1'b1);
        do_req("ld_w10",   1'b0, 32'h10, 32'h0,        2'b10, 1'b0);
        do_req("st_half",  1'b1, 32'h22, 32'h0000BEEF, 2'b01, 1'b0);
        do_req("ld_hs",    1'b0, 32'h22, 32'h0,        2'b01, 1'b0);
        do_req("ld_hu",    1'b0, 32'h22, 32'h0,        2'b01, 1'b1);
        do_req("ld_w20",   1'b0, 32'h20, 32'h0,        2'b10, 1'b0);
        do_req("st_rsvd",  1'b1, 32'h30, 32'hA5A55A5A, 2'b11, 1'b0);
        do_req("ld_rsvd",  1'b0, 32'h30, 32'h0,        2'b11, 1'b0);
`ifdef DMEM_FAULT_EN
        do_req("f_mis",    1'b0, 32'h11,      32'h0,        2'b10, 1'b0);
        do_req("f_mis_h",  1'b0, 32'h21,      32'h0,        2'b01, 1'b0);
        do_req("f_range",  1'b1, DEPTH * 4,   32'h55AA55AA, 2'b10, 1'b0);
        do_req("f_chk0",   1'b0, 32'h0,       32'h0,        2'b10, 1'b0);
`else
        do_req("wrap_st",  1'b1, DEPTH * 4 + 5, 32'h13579BDF, 2'b10, 1'b0);
        do_req("wrap_ld",  1'b0, 32'h0,         32'h0,        2'b10, 1'b0);
`endif
        do_req("ld_pre",   1'b0, 32'h10, 32'h0, 2'b10, 1'b0);

        // Reset lands on the would-be commit edge of this store.
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_write_i = 1'b1; bus.req_addr_i = 32'h40;
        bus.req_wdata_i = 32'h12345678; bus.req_size_i = 2'b10; bus.req_unsigned_i = 1'b0;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check_eq("mrst.stall", 32'(bus.stall_o), 32'd0);
        check_eq("mrst.ready", 32'(bus.req_ready_o), 32'd0);
        @(negedge clk);
        check_eq("mrst.valid", 32'(bus.resp_valid_o), 32'd0);
        check_eq("mrst.rdata", bus.resp_rdata_o, 32'd0);
        reset_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("mrst.no_resp", 32'(bus.resp_valid_o), 32'd0);
        end
        do_req("mrst.ld40", 1'b0, 32'h40, 32'h0, 2'b10, 1'b0);

        for (int i = 0; i < 300; i++) begin
`ifdef DMEM_FAULT_EN
            a = $urandom_range(0, DEPTH * 4 + 15);
`else
            a = $urandom;
`endif
            do_req("rand", 1'($urandom_range(0, 1)), a, $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Zero-wait instance: store then continuous loads, one response every two cycles.
        @(negedge clk);
        bus_z.req_valid_i = 1'b1; bus_z.req_write_i = 1'b1; bus_z.req_addr_i = 32'h8;
        bus_z.req_wdata_i = 32'hCAFE0001; bus_z.req_size_i = 2'b10; bus_z.req_unsigned_i = 1'b0;
        @(posedge clk);
        #1 bus_z.req_valid_i = 1'b0;
        @(negedge clk);
        check_eq("z.st_resp", 32'(bus_z.resp_valid_o), 32'd1);
        @(negedge clk);
        bus_z.req_valid_i = 1'b1; bus_z.req_write_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i % 2 == 0) begin
                check_eq("z.ready_idle", 32'(bus_z.req_ready_o), 32'd1);
                check_eq("z.valid_idle", 32'(bus_z.resp_valid_o), 32'd0);
                check_eq("z.stall_idle", 32'(bus_z.stall_o), 32'd1);
            end else begin
                check_eq("z.ready_resp", 32'(bus_z.req_ready_o), 32'd0);
                check_eq("z.valid_resp", 32'(bus_z.resp_valid_o), 32'd1);
                check_eq("z.stall_resp", 32'(bus_z.stall_o), 32'd0);
                check_eq("z.rdata",      bus_z.resp_rdata_o, 32'hCAFE0001);
            end
            @(negedge clk);
        end
        bus_z.req_valid_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Data-memory responder serving the pipeline's memory stage: accepts one load/store request at a time, inserts a configurable number of wait states, and returns the (sign/zero-extended) load data that the memory/writeback pipeline register captures. It also raises a stall to freeze the upstream pipeline registers while an access is in flight. Byte, halfword and word accesses; byte-lane writes into an internal word-organised array.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
- WAIT_STATES, 2, extra cycles between accept and commit (0..15)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- reset_i  in  1  synchronous, active-low reset (0 = reset)
- req_valid_i  in  1  memory stage presents a request
- req_write_i  in  1  1 = store, 0 = load
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- req_unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend
- req_ready_o  out  1  request accepted this cycle when high with req_valid_i
- resp_valid_o  out  1  one-cycle response strobe
- resp_rdata_o  out  32  extended load data (0 for stores and faults)
- resp_fault_o  out  1  access faulted; qualified by resp_valid_o
- stall_o  out  1  hold upstream pipeline registers

## Operation
- FSM states: IDLE, WAIT, RESP. Reset forces IDLE, counter 0.
- IDLE: req_ready_o = 1. On req_valid_i: latch write/addr/wdata/size/unsigned. If WAIT_STATES>0 load counter with WAIT_STATES-1, go WAIT; else commit and go RESP.
- WAIT: counter decrements each cycle; at counter==0, commit and go RESP. New requests ignored (req_ready_o = 0).
- Commit edge: store writes byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2,+1; word: all); load reads word addr[31:2], selects lane, extends per unsigned flag into resp_rdata_o register.
- RESP: resp_valid_o = 1 for exactly one cycle, then IDLE. No request accepted in RESP.
- stall_o = (IDLE & req_valid_i) | WAIT. Low in RESP so the pipeline advances with valid data.
- Array contents are not reset.

## Timing
- Request accepted at edge N; resp_valid_o high in cycle N+1+WAIT_STATES.
- Back-to-back requests: next accept earliest one cycle after RESP (throughput 1 per WAIT_STATES+2 cycles).
- Reset values: req_ready_o 0 while reset_i=0, resp_valid_o 0, resp_rdata_o 0, resp_fault_o 0, stall_o 0.
- Reset mid-operation (WAIT): request abandoned, no store committed, no response issued; IDLE on next edge after reset_i returns high.
- Fault response (when enabled): skips WAIT, RESP at N+1, no array write.

## Configuration
- DMEM_FAULT_EN defined: halfword with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= DEPTH_WORDS faults; resp_fault_o=1, resp_rdata_o=0, store suppressed.
- Not defined: no checks; addr low bits masked to size alignment, word index wraps modulo DEPTH_WORDS; resp_fault_o tied 0; all accesses take normal latency.

## Test plan
- WAIT_STATES=2, store word 0xDEADBEEF @0x10 at cycle 5 -> resp_valid_o cycle 8, stall_o high cycles 5-7; load @0x10 -> resp_rdata_o 0xDEADBEEF.
- Store byte 0x80 @0x13 then signed byte load @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word load @0x10 -> 0x80ADBEEF.
- Store half 0xBEEF @0x22, signed half load -> 0xFFFFBEEF; unsigned -> 0x0000BEEF; lanes [15:0] of word 0x20 unchanged.
- DMEM_FAULT_EN: word load @0x11 -> resp_valid_o next cycle, resp_fault_o 1, rdata 0; store @ DEPTH_WORDS*4 -> fault, array unchanged.
- reset_i low during WAIT of store 0x12345678 @0x40 -> no resp_valid_o, later load @0x40 returns prior value.
- WAIT_STATES=0, continuous req_valid_i loads -> resp every 2 cycles, req_ready_o low in RESP.
